// File: rtl/reorder_buffer_p_pkg.sv
// Shared definitions for the reorder buffer: entry kinds and default sizing.
// The tag-width helper keeps every user of the buffer deriving TAG_W the same way.
`define ROB_TAG_W(depth) $clog2(depth)

package reorder_buffer_p_pkg;

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_STORE  = 2'd2,
        KIND_LOAD   = 2'd3
    } rob_kind_e;

    localparam int ROB_DEFAULT_DEPTH = 16;
    localparam int ROB_DEFAULT_XLEN  = 32;

endpackage

// File: rtl/rob_wrap_ptr.sv
// Wrapping circular-buffer pointer; the power-of-two depth lets the natural
// binary overflow implement the modulo.
module rob_wrap_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= ptr_reg + W'(1);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/reorder_buffer_p.sv
// In-order retirement buffer: allocates at tail, collects results from two CDBs,
// forwards operands combinationally and retires one entry per cycle from head.
module reorder_buffer_p
    import reorder_buffer_p_pkg::*;
#(
    parameter int DEPTH = ROB_DEFAULT_DEPTH,
    parameter int XLEN  = ROB_DEFAULT_XLEN,
    parameter int REG_W = 5,
    parameter int TAG_W = `ROB_TAG_W(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             is_valid,
    output logic             is_ready,
    input  logic [1:0]       is_kind,
    input  logic             is_done,
    input  logic [XLEN-1:0]  is_value,
    input  logic [REG_W-1:0] is_dest,
    input  logic             is_pred_taken,
    input  logic [XLEN-1:0]  is_alt_pc,
    output logic [TAG_W-1:0] is_tag,
    input  logic [TAG_W-1:0] q1_tag,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [XLEN-1:0]  q1_value,
    output logic [XLEN-1:0]  q2_value,
    input  logic             cdba_valid,
    input  logic [TAG_W-1:0] cdba_tag,
    input  logic [XLEN-1:0]  cdba_value,
    input  logic             cdbd_valid,
    input  logic [TAG_W-1:0] cdbd_tag,
    input  logic [XLEN-1:0]  cdbd_value,
    output logic             cm_reg_valid,
    output logic [REG_W-1:0] cm_reg_dest,
    output logic [XLEN-1:0]  cm_reg_value,
    output logic [TAG_W-1:0] cm_reg_tag,
    output logic             cm_st_valid,
    output logic [REG_W-1:0] cm_st_slot,
    output logic             flush_valid,
    output logic [XLEN-1:0]  flush_pc,
    output logic [TAG_W:0]   count,
    output logic             empty
);

    logic             busy_reg   [DEPTH];
    logic             done_reg   [DEPTH];
    rob_kind_e        kind_reg   [DEPTH];
    logic [XLEN-1:0]  value_reg  [DEPTH];
    logic [REG_W-1:0] dest_reg   [DEPTH];
    logic             pred_reg   [DEPTH];
    logic [XLEN-1:0]  alt_pc_reg [DEPTH];

    logic [TAG_W-1:0] head_ptr;
    logic [TAG_W-1:0] tail_ptr;
    logic [TAG_W:0]   count_reg;
    logic             alloc;
    logic             commit;
    logic             mispredict;

    logic             cm_reg_valid_reg;
    logic [REG_W-1:0] cm_reg_dest_reg;
    logic [XLEN-1:0]  cm_reg_value_reg;
    logic [TAG_W-1:0] cm_reg_tag_reg;
    logic             cm_st_valid_reg;
    logic [REG_W-1:0] cm_st_slot_reg;
    logic             flush_valid_reg;
    logic [XLEN-1:0]  flush_pc_reg;

    // is_ready looks only at the registered count, so a slot freed this cycle is not reused until the next.
    assign is_ready   = count_reg < (TAG_W+1)'(DEPTH);
    assign alloc      = rdy && is_valid && is_ready;
    assign commit     = rdy && busy_reg[head_ptr] && done_reg[head_ptr];
    assign mispredict = commit && (kind_reg[head_ptr] == KIND_BRANCH)
                        && (value_reg[head_ptr][0] != pred_reg[head_ptr]);

    rob_wrap_ptr #(.W(TAG_W)) u_head (
        .clk (clk),
        .rst (rst),
        .clr (mispredict),
        .inc (commit),
        .ptr (head_ptr)
    );

    rob_wrap_ptr #(.W(TAG_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .clr (mispredict),
        .inc (alloc),
        .ptr (tail_ptr)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic sel_alloc;
            logic sel_commit;
            logic wr_a;
            logic wr_d;

            assign sel_alloc  = alloc && (tail_ptr == TAG_W'(gi));
            assign sel_commit = commit && (head_ptr == TAG_W'(gi));
            assign wr_d = rdy && cdbd_valid && (cdbd_tag == TAG_W'(gi)) && busy_reg[gi];
            // The ALU bus only carries a LOAD's address, never its data.
            assign wr_a = rdy && cdba_valid && (cdba_tag == TAG_W'(gi)) && busy_reg[gi]
                          && (kind_reg[gi] != KIND_LOAD);

            always_ff @(posedge clk) begin
                if (rst || mispredict) begin
                    busy_reg[gi] <= 1'b0;
                    done_reg[gi] <= 1'b0;
                end else if (sel_alloc) begin
                    busy_reg[gi] <= 1'b1;
                    done_reg[gi] <= is_done;
                end else begin
                    if (sel_commit) begin
                        busy_reg[gi] <= 1'b0;
                    end
                    if (wr_a || wr_d) begin
                        done_reg[gi] <= 1'b1;
                    end
                end
            end

            // Payload needs no reset: it is only observed while busy.
            always_ff @(posedge clk) begin
                if (sel_alloc) begin
                    value_reg[gi]  <= is_value;
                    kind_reg[gi]   <= rob_kind_e'(is_kind);
                    dest_reg[gi]   <= is_dest;
                    pred_reg[gi]   <= is_pred_taken;
                    alt_pc_reg[gi] <= is_alt_pc;
                end else if (wr_d) begin
                    value_reg[gi] <= cdbd_value;
                end else if (wr_a) begin
                    value_reg[gi] <= cdba_value;
                end
            end
        end
    endgenerate

    logic [TAG_W-1:0] q_tag   [2];
    logic             q_rdy   [2];
    logic [XLEN-1:0]  q_val   [2];

    assign q_tag[0] = q1_tag;
    assign q_tag[1] = q2_tag;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_lookup
            always_comb begin
                q_rdy[gi] = 1'b0;
                q_val[gi] = value_reg[q_tag[gi]];
                if (busy_reg[q_tag[gi]]) begin
                    if (cdbd_valid && (cdbd_tag == q_tag[gi])) begin
                        q_rdy[gi] = 1'b1;
                        q_val[gi] = cdbd_value;
                    end else if (cdba_valid && (cdba_tag == q_tag[gi])
                                 && (kind_reg[q_tag[gi]] != KIND_LOAD)) begin
                        q_rdy[gi] = 1'b1;
                        q_val[gi] = cdba_value;
                    end else begin
                        q_rdy[gi] = done_reg[q_tag[gi]];
                    end
                end
            end
        end
    endgenerate

    assign q1_ready = q_rdy[0];
    assign q1_value = q_val[0];
    assign q2_ready = q_rdy[1];
    assign q2_value = q_val[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            cm_reg_valid_reg <= 1'b0;
            cm_reg_dest_reg  <= '0;
            cm_reg_value_reg <= '0;
            cm_reg_tag_reg   <= '0;
            cm_st_valid_reg  <= 1'b0;
            cm_st_slot_reg   <= '0;
            flush_valid_reg  <= 1'b0;
            flush_pc_reg     <= '0;
        end else begin
            // Valids are recomputed every edge, so pulses last exactly one cycle.
            cm_reg_valid_reg <= commit && ((kind_reg[head_ptr] == KIND_REG)
                                           || (kind_reg[head_ptr] == KIND_LOAD));
            cm_st_valid_reg  <= commit && (kind_reg[head_ptr] == KIND_STORE);
            flush_valid_reg  <= mispredict;
            if (commit) begin
                cm_reg_dest_reg  <= dest_reg[head_ptr];
                cm_reg_value_reg <= value_reg[head_ptr];
                cm_reg_tag_reg   <= head_ptr;
                cm_st_slot_reg   <= dest_reg[head_ptr];
            end
            if (mispredict) begin
                flush_pc_reg <= alt_pc_reg[head_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || mispredict) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + (TAG_W+1)'(alloc) - (TAG_W+1)'(commit);
        end
    end

    assign is_tag       = tail_ptr;
    assign count        = count_reg;
    assign empty        = (count_reg == '0);
    assign cm_reg_valid = cm_reg_valid_reg;
    assign cm_reg_dest  = cm_reg_dest_reg;
    assign cm_reg_value = cm_reg_value_reg;
    assign cm_reg_tag   = cm_reg_tag_reg;
    assign cm_st_valid  = cm_st_valid_reg;
    assign cm_st_slot   = cm_st_slot_reg;
    assign flush_valid  = flush_valid_reg;
    assign flush_pc     = flush_pc_reg;

endmodule
